// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VRAM write path of the VGA tile display
// (40x30 tiles = 1200 cells, 2-bit colour per cell).
//   VRAM_CELLS / VRAM_ADDR_W / COLOR_W : geometry of the VRAM write port
//   vram_wr_t                          : one queued cell write {addr, data}
//   sched_state_t                      : write scheduler FSM states
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int VRAM_CELLS  = 1200;
  localparam int VRAM_ADDR_W = 11;
  localparam int COLOR_W     = 2;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [COLOR_W-1:0]     data;
  } vram_wr_t;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    FILL_WAIT = 2'd1,
    FILL      = 2'd2
  } sched_state_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO: rdata always shows the oldest
// entry while empty=0. Synchronous active-low reset flushes the pointers.
//   clk, rst_n     : clock, synchronous active-low reset
//   push, wdata    : write one entry (ignored when full)
//   pop, rdata     : consume the head entry (ignored when empty)
//   full, empty    : occupancy flags
//   level          : current number of entries (0..DEPTH)
// ---------------------------------------------------------------------------
module sync_fifo
  import vga_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = vram_wr_t,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  T               wdata,
  input  logic           pop,
  output T               rdata,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] level
);

  T               mem_q [DEPTH];
  logic [PTR_W:0] wr_ptr_q;
  logic [PTR_W:0] rd_ptr_q;
  logic           push_ok;
  logic           pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (level == (PTR_W+1)'(DEPTH));
  assign rdata = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/vram_write_scheduler.sv
// ---------------------------------------------------------------------------
// vram_write_scheduler
// Queues CPU cell writes, adds a whole-screen fill engine, and commits all
// VRAM writes only while the commit window is open (vblank when TEAR_FREE=1)
// so the visible frame never tears. Command order is preserved: a fill runs
// only after every CPU write accepted up to and including its start cycle.
//
//   sys_clock, reset            : clock, synchronous active-low reset
//   cpu_req_valid/ready/addr/data : CPU write handshake
//   fill_start, fill_color      : one-cycle fill request and its colour
//   vblank                      : commit window level from the sync unit
//   vram_we/addr/data           : registered VRAM write port
//   fill_busy                   : fill accepted and not yet complete
//   fifo_level                  : CPU FIFO occupancy
//   idle                        : FIFO empty and no fill pending
//
// state     | meaning
// ----------+---------------------------------------------------------------
// RUN       | normal: accept CPU writes, drain FIFO in window, take fills
// FILL_WAIT | fill latched; CPU blocked, drain older CPU writes first
// FILL      | write fill colour to cells 0..NUM_CELLS-1 while window open
// ---------------------------------------------------------------------------
module vram_write_scheduler
  import vga_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = COLOR_W,
  parameter int NUM_CELLS  = VRAM_CELLS,
  parameter int FIFO_DEPTH = 16,
  parameter bit TEAR_FREE  = 1'b1
) (
  input  logic                        sys_clock,
  input  logic                        reset,
  input  logic                        cpu_req_valid,
  output logic                        cpu_req_ready,
  input  logic [ADDR_W-1:0]           cpu_req_addr,
  input  logic [DATA_W-1:0]           cpu_req_data,
  input  logic                        fill_start,
  input  logic [DATA_W-1:0]           fill_color,
  input  logic                        vblank,
  output logic                        vram_we,
  output logic [ADDR_W-1:0]           vram_addr,
  output logic [DATA_W-1:0]           vram_data,
  output logic                        fill_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        idle
);

  localparam int                LVL_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CELLS - 1);

  sched_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [DATA_W-1:0] fill_color_q, fill_color_d;
  logic              fill_busy_q, fill_busy_d;
  logic              vram_we_q, vram_we_d;
  logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic [DATA_W-1:0] vram_data_q, vram_data_d;

  logic              win;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  level;
  vram_wr_t          push_wr;
  vram_wr_t          head_wr;

  assign win = vblank | ~TEAR_FREE;

  // Ready is forced low while reset is held so nothing is accepted then.
  assign cpu_req_ready = reset & ~fifo_full & (state_q == RUN);
  assign push          = cpu_req_valid & cpu_req_ready;

  assign push_wr.addr = VRAM_ADDR_W'(cpu_req_addr);
  assign push_wr.data = COLOR_W'(cpu_req_data);

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (vram_wr_t)
  ) u_fifo (
    .clk   (sys_clock),
    .rst_n (reset),
    .push  (push),
    .wdata (push_wr),
    .pop   (pop),
    .rdata (head_wr),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_comb begin
    state_d      = state_q;
    fill_addr_d  = fill_addr_q;
    fill_color_d = fill_color_q;
    fill_busy_d  = fill_busy_q;
    vram_we_d    = 1'b0;
    vram_addr_d  = vram_addr_q;
    vram_data_d  = vram_data_q;
    pop          = 1'b0;

    // The FIFO is always empty in FILL (CPU is blocked from FILL_WAIT on),
    // so the fill engine and the FIFO never compete for the port.
    if ((state_q != FILL) && win && !fifo_empty) begin
      pop         = 1'b1;
      vram_we_d   = 1'b1;
      vram_addr_d = ADDR_W'(head_wr.addr);
      vram_data_d = DATA_W'(head_wr.data);
    end

    unique case (state_q)
      RUN: begin
        // Only sampled in RUN, so a pulse during a fill is ignored.
        if (fill_start) begin
          fill_color_d = fill_color;
          fill_busy_d  = 1'b1;
          state_d      = FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        if (fifo_empty) begin
          fill_addr_d = '0;
          state_d     = FILL;
        end
      end
      FILL: begin
        if (win) begin
          vram_we_d   = 1'b1;
          vram_addr_d = fill_addr_q;
          vram_data_d = fill_color_q;
          if (fill_addr_q == LAST_ADDR) begin
            fill_busy_d = 1'b0;
            state_d     = RUN;
          end else begin
            fill_addr_d = fill_addr_q + 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (!reset) begin
      state_q      <= RUN;
      fill_addr_q  <= '0;
      fill_color_q <= '0;
      fill_busy_q  <= 1'b0;
      vram_we_q    <= 1'b0;
      vram_addr_q  <= '0;
      vram_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      fill_addr_q  <= fill_addr_d;
      fill_color_q <= fill_color_d;
      fill_busy_q  <= fill_busy_d;
      vram_we_q    <= vram_we_d;
      vram_addr_q  <= vram_addr_d;
      vram_data_q  <= vram_data_d;
    end
  end

  assign vram_we    = vram_we_q;
  assign vram_addr  = vram_addr_q;
  assign vram_data  = vram_data_q;
  assign fill_busy  = fill_busy_q;
  assign fifo_level = level;
  assign idle       = ~reset | (fifo_empty & (state_q == RUN));

endmodule
